refund_dispenser: RTL and testbench

Pays out a computed refund amount as physical coins after the refund has been calculated as money minus price. It takes a 13-bit amount in cents with a start strobe and drives a coin hopper through a valid/ready handshake, one coin per transfer. Coin selection is greedy, largest denomination first, and skips any denomination whose hopper tube reports empty. When the payout finishes or cannot be completed, the block raises `done` and reports any unpaid remainder.

---
 rtl/vending_pkg.sv | 32 +++
 rtl/coin_select.sv | 25 ++
 rtl/refund_dispenser.sv | 106 ++++++++++
 tb/tb_refund_dispenser.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared coin denomination table and FSM encoding
package vending_pkg;

  localparam int NUM_COINS = 5;

  localparam logic [2:0] COIN_100 = 3'd0;
  localparam logic [2:0] COIN_25  = 3'd1;
  localparam logic [2:0] COIN_10  = 3'd2;
  localparam logic [2:0] COIN_5   = 3'd3;
  localparam logic [2:0] COIN_1   = 3'd4;

  localparam logic [12:0] COIN_VAL [0:NUM_COINS-1] = '{13'd100, 13'd25, 13'd10, 13'd5, 13'd1};

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SELECT   = 2'd1;
  localparam logic [1:0] ST_DISPENSE = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  function automatic logic [12:0] coin_value(input logic [2:0] sel);
    logic [12:0] v;
    case (sel)
      COIN_100: v = COIN_VAL[0];
      COIN_25:  v = COIN_VAL[1];
      COIN_10:  v = COIN_VAL[2];
      COIN_5:   v = COIN_VAL[3];
      COIN_1:   v = COIN_VAL[4];
      default:  v = 13'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// rtl/coin_select.sv - greedy picker: largest non-empty coin not exceeding remaining
module coin_select
  import vending_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0]     remaining,
  input  logic [NUM_COINS-1:0] coin_empty,
  output logic [2:0]           sel,
  output logic                 found
);

  // Scan from the smallest coin up so the largest qualifying one wins.
  always_comb begin
    sel   = 3'd0;
    found = 1'b0;
    for (int k = NUM_COINS - 1; k >= 0; k--) begin
      if (!coin_empty[k] && (WIDTH'(COIN_VAL[k]) <= remaining)) begin
        sel   = 3'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/refund_dispenser.sv
// rtl/refund_dispenser.sv - pays a refund out one coin per hopper handshake
module refund_dispenser
  import vending_pkg::*;
#(
  parameter int WIDTH      = 13,
  parameter int MAX_REFUND = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic [4:0]       coin_empty,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [2:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] remaining,
  output logic [WIDTH-1:0] coin_cnt
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             err_q, err_d;
  logic [2:0]       pick_sel;
  logic             pick_found;

  coin_select #(.WIDTH(WIDTH)) u_coin_select (
    .remaining  (rem_q),
    .coin_empty (coin_empty),
    .sel        (pick_sel),
    .found      (pick_found)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d = amount;
          cnt_d = '0;
          // Amounts above the limit are a wrapped negative money-minus-price.
          if (amount > WIDTH'(MAX_REFUND)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_SELECT;
          end
        end
      end
      ST_SELECT: begin
        if (rem_q == '0) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (pick_found) begin
          sel_d   = pick_sel;
          state_d = ST_DISPENSE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DISPENSE: begin
        if (coin_ready) begin
          rem_d   = rem_q - WIDTH'(coin_value(sel_q));
          cnt_d   = cnt_q + WIDTH'(1);
          state_d = ST_SELECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign coin_valid = (state_q == ST_DISPENSE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign coin_sel   = sel_q;
  assign err        = err_q;
  assign remaining  = rem_q;
  assign coin_cnt   = cnt_q;

endmodule

// File: tb/tb_refund_dispenser.sv
// tb/tb_refund_dispenser.sv - directed bench with a per-cycle payout model
module tb_refund_dispenser;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [12:0] amount;
  logic [4:0]  coin_empty;
  logic        coin_ready;
  logic        coin_valid;
  logic [2:0]  coin_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [12:0] remaining;
  logic [12:0] coin_cnt;

  refund_dispenser #(.WIDTH(13), .MAX_REFUND(4095)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .amount     (amount),
    .coin_empty (coin_empty),
    .coin_ready (coin_ready),
    .coin_valid (coin_valid),
    .coin_sel   (coin_sel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .remaining  (remaining),
    .coin_cnt   (coin_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int neg_cnt = 0;
  int t0 = 0;

  always @(negedge clk) neg_cnt <= neg_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a run is a greedy list of coins; coin i is offered at edge 1+2i+stalls.
  int val_tab [5] = '{100, 25, 10, 5, 1};
  int m_list[$];
  int m_amt, m_paid, m_idx, m_n, m_stall, m_edge;
  bit m_rej, m_short, m_active, m_en, m_rst_pend;
  int h_rem, h_cnt, h_err;

  initial begin
    m_active = 0; m_en = 0; m_rst_pend = 0;
    h_rem = 0; h_cnt = 0; h_err = 0;
  end

  always @(negedge clk) begin
    bit valid_exp, done_exp;
    int rem;
    bit found;
    if (m_rst_pend) begin
      chk("rst_valid", int'(coin_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_remaining", int'(remaining), 0);
      chk("rst_coin_cnt", int'(coin_cnt), 0);
      chk("rst_coin_sel", int'(coin_sel), 0);
      m_active = 0; m_en = 1;
      h_rem = 0; h_cnt = 0; h_err = 0;
    end else if (m_en) begin
      if (m_active) begin
        m_edge++;
        valid_exp = !m_rej && (m_idx < m_n) && (m_edge == 1 + 2 * m_idx + m_stall);
        done_exp  = m_rej ? (m_edge == 0) : ((m_idx == m_n) && (m_edge == 1 + 2 * m_n + m_stall));
        chk("run_busy", int'(busy), 1);
        chk("run_valid", int'(coin_valid), int'(valid_exp));
        chk("run_done", int'(done), int'(done_exp));
        chk("run_remaining", int'(remaining), m_amt - m_paid);
        chk("run_coin_cnt", int'(coin_cnt), m_idx);
        chk("run_err", int'(err), m_rej ? 1 : (done_exp ? int'(m_short) : 0));
        if (valid_exp) begin
          chk("run_coin_sel", int'(coin_sel), m_list[m_idx]);
          if (coin_ready) begin
            m_paid += val_tab[m_list[m_idx]];
            m_idx++;
          end else begin
            m_stall++;
          end
        end
        if (done_exp) begin
          m_active = 0;
          h_rem = m_amt - m_paid;
          h_cnt = m_idx;
          h_err = (m_rej || m_short) ? 1 : 0;
        end else if (m_edge > 400) begin
          chk("run_timeout", m_edge, 0);
          m_active = 0;
        end
      end else begin
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_valid", int'(coin_valid), 0);
        chk("idle_remaining", int'(remaining), h_rem);
        chk("idle_coin_cnt", int'(coin_cnt), h_cnt);
        chk("idle_err", int'(err), h_err);
        if (start && rst_n) begin
          m_amt = int'(amount);
          m_rej = (amount > 13'd4095);
          m_list.delete();
          rem = m_amt;
          if (!m_rej) begin
            while (rem > 0) begin
              found = 0;
              for (int k = 0; k < 5; k++) begin
                if (!found && !coin_empty[k] && val_tab[k] <= rem) begin
                  m_list.push_back(k);
                  rem -= val_tab[k];
                  found = 1;
                end
              end
              if (!found) break;
            end
          end
          m_short = (rem != 0);
          m_n = m_list.size();
          m_paid = 0; m_idx = 0; m_stall = 0; m_edge = -1;
          m_active = 1;
        end
      end
    end
    m_rst_pend = !rst_n;
  end

  task automatic run_start(input int a, input logic [4:0] e);
    @(posedge clk); #1;
    amount = 13'(a);
    coin_empty = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = neg_cnt;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_cnt,
                           input int exp_rem, input int exp_err);
    bit seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      chk({name, "_latency"}, neg_cnt - t0 - 1, exp_lat);
      chk({name, "_coin_cnt"}, int'(coin_cnt), exp_cnt);
      chk({name, "_remaining"}, int'(remaining), exp_rem);
      chk({name, "_err"}, int'(err), exp_err);
    end
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; amount = '0; coin_empty = '0; coin_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_start(141, 5'b00000);
    chk("t1_model_n", m_n, 5);
    for (int i = 0; i < 5; i++) chk("t1_model_code", m_list[i], i);
    wait_done("t1", 11, 5, 0, 0);

    run_start(0, 5'b00000);
    wait_done("t2", 1, 0, 0, 0);

    run_start(60, 5'b00010);
    wait_done("t3", 13, 6, 0, 0);

    run_start(8, 5'b10000);
    wait_done("t4", 3, 1, 3, 1);

    run_start(5000, 5'b00000);
    wait_done("t5", 0, 0, 5000, 1);

    coin_ready = 1'b0;
    run_start(30, 5'b00000);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (coin_valid) begin
        seen = 1;
        break;
      end
    end
    chk("t6_valid_seen", int'(seen), 1);
    chk("t6_sel_first", int'(coin_sel), 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      start = (i == 0);
      amount = 13'd7;
      @(negedge clk); #1;
      chk("t6_valid_stall", int'(coin_valid), 1);
      chk("t6_sel_stall", int'(coin_sel), 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    coin_ready = 1'b1;
    wait_done("t6", 8, 2, 0, 0);

    coin_ready = 1'b0;
    run_start(100, 5'b00000);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (coin_valid) begin
        seen = 1;
        break;
      end
    end
    chk("t7_valid_seen", int'(seen), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    coin_ready = 1'b1;
    @(negedge clk); #1;
    chk("t7_valid_after_rst", int'(coin_valid), 0);
    chk("t7_busy_after_rst", int'(busy), 0);
    chk("t7_remaining_after_rst", int'(remaining), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t7_no_done", int'(done), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
